mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Shares the single data-memory port between instruction fetch (IFU) and the execute-stage load/store path (LSU).
- Each requester raises a level request, holds it until it sees a one-cycle done pulse, then drops it.
- The arbiter grants one requester at a time, latches its command, and drives the memory port through an issue/response handshake.
- It returns read data and the done pulse to the owning requester only. Ties are resolved round-robin.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; write mask width is DATA_W/8

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ifu_req_i  in  1  IFU read request, level, held until ifu_done_o
ifu_addr_i  in  ADDR_W  IFU fetch address
ifu_done_o  out  1  one-cycle IFU completion pulse
ifu_rdata_o  out  DATA_W  IFU read data, valid while ifu_done_o=1
lsu_req_i  in  1  LSU request, level, held until lsu_done_o
lsu_we_i  in  1  1=store, 0=load
lsu_addr_i  in  ADDR_W  LSU address
lsu_wdata_i  in  DATA_W  store data
lsu_wmask_i  in  DATA_W/8  store byte enables
lsu_done_o  out  1  one-cycle LSU completion pulse
lsu_rdata_o  out  DATA_W  LSU load data, valid while lsu_done_o=1
mem_valid_o  out  1  command valid toward memory
mem_ready_i  in  1  memory accepts command
mem_we_o  out  1  command is a write
mem_addr_o  out  ADDR_W  command address
mem_wdata_o  out  DATA_W  write data
mem_wmask_o  out  DATA_W/8  write byte enables
mem_rvalid_i  in  1  response valid (read data or write acknowledge)
mem_rdata_i  in  DATA_W  response read data
busy_o  out  1  high in every state except IDLE

Behaviour:
- States:
  - IDLE: no grant outstanding.
  - ISSUE: mem_valid_o=1, command held.
  - WAIT: command accepted, awaiting response.
  - DONE: done pulse to owner.
- Reset (reset=0, takes effect immediately):
  - state=IDLE.
  - All outputs 0: mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o, both done_o, both rdata_o, busy_o.
  - last_owner=IFU, so the first tie goes to LSU.
  - Reset mid-transaction abandons the access and emits no done pulse.
- IDLE transitions:
  - Neither request: stay.
  - Exactly one request: grant it.
  - Both requests: grant the requester that is not last_owner.
- On grant:
  - Latch owner, we, addr, wdata and wmask into the mem_* output registers.
  - IFU grant forces mem_we_o=0 and mem_wmask_o=0.
  - Update last_owner and go to ISSUE.
- ISSUE:
  - mem_valid_o=1; all mem_* values stable until mem_ready_i=1.
  - On mem_ready_i=1, go to WAIT; mem_valid_o falls on the next cycle.
- WAIT:
  - On mem_rvalid_i=1, register mem_rdata_i into the owner's rdata_o and go to DONE.
  - Stores also register mem_rdata_i; the value is don't-care.
  - mem_rvalid_i is ignored in every state other than WAIT.
- DONE:
  - Owner's done_o=1 for exactly this cycle; the other done_o stays 0.
  - Then go to IDLE unconditionally.
  - The requester's own FSM drops req on the edge after done, so IDLE never regrants a stale request.
- rdata_o holds its value until the next response to the same requester.
- Minimum latency with mem_ready_i and mem_rvalid_i tied high: req first seen in cycle 0, done_o in cycle 3. Throughput is one access per 4 cycles.
- A requester deasserting req while it owns the grant has no effect: the access completes and the done pulse is still emitted.
- Requests raised by the non-owner while busy are held pending and considered only in IDLE.
- Round-robin guarantees neither requester waits more than one foreign access when both request continuously.
- Input commands are sampled only at grant; changes afterwards are ignored.

Test Plan:
- After reset, IFU-only read of addr 0x8000_0000 with ready=rvalid=1 and rdata 0x0000_0413 -> mem_valid_o high in cycle 1 with mem_we_o=0; ifu_done_o pulses in cycle 3 with ifu_rdata_o=0x0000_0413; lsu_done_o stays 0.
- LSU store addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0xF; hold mem_ready_i=0 for 3 cycles -> mem_valid_o and all command fields stable throughout ISSUE; lsu_done_o pulses 2 cycles after ready rises.
- Both requesting from reset and re-raising immediately after each done -> grant order LSU, IFU, LSU, IFU; each access yields exactly one done pulse to the right port.
- LSU load granted, then lsu_addr_i changed and lsu_req_i dropped during WAIT -> mem_addr_o keeps the original address; lsu_done_o still pulses once.
- mem_rvalid_i pulsed in IDLE and in ISSUE (stray) -> ignored: no state change, no done pulse.
- reset driven low during WAIT -> mem_valid_o, busy_o and both done_o go 0 immediately without a clock edge; after release, a new IFU request completes normally, and a later tie goes to LSU.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and the load/store unit.
// Round-robin grant, command latched at grant, issue/response handshake toward memory.
module mem_access_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_i,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_done_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    output logic                lsu_done_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e state;
    logic   owner;       // 1 = LSU owns the port, 0 = IFU
    logic   last_owner;  // 1 = LSU was granted last
    logic   grant_lsu;

    // On a tie the requester that did not win last time gets the port.
    assign grant_lsu = lsu_req_i && (!ifu_req_i || !last_owner);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            owner       <= 1'b0;
            last_owner  <= 1'b0;
            mem_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
            ifu_done_o  <= 1'b0;
            lsu_done_o  <= 1'b0;
            ifu_rdata_o <= '0;
            lsu_rdata_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            ifu_done_o <= 1'b0;
            lsu_done_o <= 1'b0;
            case (state)
                StIdle: begin
                    if (ifu_req_i || lsu_req_i) begin
                        owner       <= grant_lsu;
                        last_owner  <= grant_lsu;
                        mem_valid_o <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= StIssue;
                        if (grant_lsu) begin
                            mem_we_o    <= lsu_we_i;
                            mem_addr_o  <= lsu_addr_i;
                            mem_wdata_o <= lsu_wdata_i;
                            mem_wmask_o <= lsu_wmask_i;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= ifu_addr_i;
                            mem_wdata_o <= '0;
                            mem_wmask_o <= '0;
                        end
                    end
                end
                StIssue: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        state       <= StWait;
                    end
                end
                StWait: begin
                    if (mem_rvalid_i) begin
                        if (owner) begin
                            lsu_rdata_o <= mem_rdata_i;
                            lsu_done_o  <= 1'b1;
                        end else begin
                            ifu_rdata_o <= mem_rdata_i;
                            ifu_done_o  <= 1'b1;
                        end
                        state <= StDone;
                    end
                end
                StDone: begin
                    busy_o <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: one task per scenario, inline comparisons.
module tb_mem_access_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_i, ifu_done_o;
    logic [31:0] ifu_addr_i, ifu_rdata_o;
    logic        lsu_req_i, lsu_we_i, lsu_done_o;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic [3:0]  lsu_wmask_i, mem_wmask_o;
    logic        mem_valid_o, mem_ready_i, mem_we_o, mem_rvalid_i, busy_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int errors = 0;
    int checks = 0;

    mem_access_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_done_o(ifu_done_o),
        .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_wmask_i(lsu_wmask_i), .lsu_done_o(lsu_done_o),
        .lsu_rdata_o(lsu_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifu_req_i = 0; ifu_addr_i = '0; lsu_req_i = 0; lsu_we_i = 0; lsu_addr_i = '0;
        lsu_wdata_i = '0; lsu_wmask_i = '0; mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        #2;
        checks++;
        if ({mem_valid_o, mem_we_o, busy_o, ifu_done_o, lsu_done_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {mem_valid_o, mem_we_o, busy_o, ifu_done_o, lsu_done_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, mem_wmask_o, ifu_rdata_o, lsu_rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h mask=%h ir=%h lr=%h want all 0",
                     mem_addr_o, mem_wdata_o, mem_wmask_o, ifu_rdata_o, lsu_rdata_o);
        end
        tick();
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_ifu_read();
        ifu_req_i = 1; ifu_addr_i = 32'h8000_0000;
        mem_ready_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0413;
        tick();  // cycle 1
        checks++;
        if ({mem_valid_o, mem_we_o, busy_o} !== 3'b101 || mem_addr_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL ifu_issue: got v/we/busy=%b addr=%h want 101 80000000",
                     {mem_valid_o, mem_we_o, busy_o}, mem_addr_o);
        end
        tick();  // cycle 2
        checks++;
        if ({mem_valid_o, ifu_done_o, lsu_done_o} !== 3'b000) begin
            errors++;
            $display("FAIL ifu_wait: got v/id/ld=%b want 000", {mem_valid_o, ifu_done_o, lsu_done_o});
        end
        tick();  // cycle 3
        checks++;
        if ({ifu_done_o, lsu_done_o} !== 2'b10 || ifu_rdata_o !== 32'h0000_0413) begin
            errors++;
            $display("FAIL ifu_done: got id/ld=%b rdata=%h want 10 00000413",
                     {ifu_done_o, lsu_done_o}, ifu_rdata_o);
        end
        ifu_req_i = 0;
        tick();  // cycle 4
        checks++;
        if ({ifu_done_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL ifu_idle: got done/busy=%b want 00", {ifu_done_o, busy_o});
        end
    endtask

    task automatic test_store_stall();
        lsu_req_i = 1; lsu_we_i = 1; lsu_addr_i = 32'h8000_1000;
        lsu_wdata_i = 32'hDEAD_BEEF; lsu_wmask_i = 4'hF;
        mem_ready_i = 0; mem_rvalid_i = 0;
        tick();  // cycle 1
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_valid_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h8000_1000 ||
                mem_wdata_o !== 32'hDEAD_BEEF || mem_wmask_o !== 4'hF) begin
                errors++;
                $display("FAIL store_hold[%0d]: got v=%b we=%b a=%h d=%h m=%h want 1 1 80001000 deadbeef f",
                         i, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o);
            end
            tick();
        end
        mem_ready_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h5555_AAAA;
        tick();  // one cycle after ready rose
        checks++;
        if ({mem_valid_o, lsu_done_o} !== 2'b00) begin
            errors++;
            $display("FAIL store_wait: got v/ld=%b want 00", {mem_valid_o, lsu_done_o});
        end
        tick();  // two cycles after ready rose
        checks++;
        if ({lsu_done_o, ifu_done_o} !== 2'b10) begin
            errors++;
            $display("FAIL store_done: got ld/id=%b want 10", {lsu_done_o, ifu_done_o});
        end
        lsu_req_i = 0; lsu_we_i = 0;
        tick();
    endtask

    task automatic test_round_robin();
        logic        exp_lsu;
        logic [31:0] exp_addr;
        reset = 0;
        #2 reset = 1;
        ifu_req_i = 1; ifu_addr_i = 32'h0000_0100;
        lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h0000_0200;
        mem_ready_i = 1; mem_rvalid_i = 1;
        for (int k = 0; k < 4; k++) begin
            exp_lsu  = (k % 2 == 0);
            exp_addr = exp_lsu ? 32'h0000_0200 : 32'h0000_0100;
            mem_rdata_i = 32'h1000 + k;
            tick();
            checks++;
            if (mem_addr_o !== exp_addr || mem_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got addr=%h v=%b want %h 1", k, mem_addr_o,
                         mem_valid_o, exp_addr);
            end
            tick();
            checks++;
            if ({ifu_done_o, lsu_done_o} !== 2'b00) begin
                errors++;
                $display("FAIL rr_early[%0d]: got id/ld=%b want 00", k, {ifu_done_o, lsu_done_o});
            end
            tick();
            checks++;
            if ({lsu_done_o, ifu_done_o} !== {exp_lsu, !exp_lsu} ||
                (exp_lsu ? lsu_rdata_o : ifu_rdata_o) !== 32'h1000 + k) begin
                errors++;
                $display("FAIL rr_done[%0d]: got ld/id=%b ir=%h lr=%h want %b data %h", k,
                         {lsu_done_o, ifu_done_o}, ifu_rdata_o, lsu_rdata_o,
                         {exp_lsu, !exp_lsu}, 32'h1000 + k);
            end
            if (exp_lsu) lsu_req_i = 0; else ifu_req_i = 0;
            tick();
            if (k < 3) begin
                if (exp_lsu) lsu_req_i = 1; else ifu_req_i = 1;
            end else begin
                ifu_req_i = 0; lsu_req_i = 0;
            end
        end
        tick();
    endtask

    task automatic test_addr_change();
        lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h8000_2000;
        mem_ready_i = 1; mem_rvalid_i = 0;
        tick();  // issue
        tick();  // wait
        lsu_addr_i = 32'h0000_1234; lsu_req_i = 0;
        tick();
        checks++;
        if (mem_addr_o !== 32'h8000_2000 || lsu_done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL chg_hold: got addr=%h ld=%b busy=%b want 80002000 0 1",
                     mem_addr_o, lsu_done_o, busy_o);
        end
        mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
        tick();
        checks++;
        if (lsu_done_o !== 1'b1 || lsu_rdata_o !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL chg_done: got ld=%b rdata=%h want 1 cafef00d", lsu_done_o, lsu_rdata_o);
        end
        mem_rvalid_i = 0;
        tick();
        checks++;
        if ({lsu_done_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL chg_once: got ld/busy=%b want 00", {lsu_done_o, busy_o});
        end
    endtask

    task automatic test_stray_rvalid();
        mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
        tick();
        tick();
        checks++;
        if ({busy_o, mem_valid_o, ifu_done_o, lsu_done_o} !== 4'b0000) begin
            errors++;
            $display("FAIL stray_idle: got b/v/id/ld=%b want 0000",
                     {busy_o, mem_valid_o, ifu_done_o, lsu_done_o});
        end
        ifu_req_i = 1; ifu_addr_i = 32'h8000_0040;
        tick();  // issue, ready low
        tick();
        checks++;
        if ({busy_o, mem_valid_o, ifu_done_o, lsu_done_o} !== 4'b1100) begin
            errors++;
            $display("FAIL stray_issue: got b/v/id/ld=%b want 1100",
                     {busy_o, mem_valid_o, ifu_done_o, lsu_done_o});
        end
        mem_ready_i = 1; mem_rvalid_i = 0;
        tick();  // wait
        tick();
        checks++;
        if ({busy_o, ifu_done_o} !== 2'b10) begin
            errors++;
            $display("FAIL stray_wait: got busy/id=%b want 10", {busy_o, ifu_done_o});
        end
        mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
        tick();
        checks++;
        if (ifu_done_o !== 1'b1 || ifu_rdata_o !== 32'h0000_0013) begin
            errors++;
            $display("FAIL stray_done: got id=%b rdata=%h want 1 00000013", ifu_done_o, ifu_rdata_o);
        end
        ifu_req_i = 0; mem_rvalid_i = 0;
        tick();
    endtask

    task automatic test_reset_wait();
        ifu_req_i = 1; ifu_addr_i = 32'h8000_0080;
        mem_ready_i = 1; mem_rvalid_i = 0;
        tick();  // issue
        tick();  // wait
        #2 reset = 0;
        #1;
        checks++;
        if ({mem_valid_o, busy_o, ifu_done_o, lsu_done_o} !== 4'b0000 || mem_addr_o !== '0) begin
            errors++;
            $display("FAIL rst_wait: got v/b/id/ld=%b addr=%h want 0000 0",
                     {mem_valid_o, busy_o, ifu_done_o, lsu_done_o}, mem_addr_o);
        end
        #2 reset = 1;
        mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0297;
        tick();  // cycle 1 of fresh IFU access
        tick();
        tick();
        checks++;
        if (ifu_done_o !== 1'b1 || ifu_rdata_o !== 32'h0000_0297) begin
            errors++;
            $display("FAIL rst_again: got id=%b rdata=%h want 1 00000297", ifu_done_o, ifu_rdata_o);
        end
        ifu_req_i = 0;
        tick();
        // Both request after an IFU access: LSU must win.
        ifu_req_i = 1; lsu_req_i = 1; lsu_we_i = 1; lsu_addr_i = 32'h8000_3000;
        lsu_wdata_i = 32'h1234_5678; lsu_wmask_i = 4'h3;
        tick();
        checks++;
        if (mem_addr_o !== 32'h8000_3000 || mem_we_o !== 1'b1 || mem_wmask_o !== 4'h3) begin
            errors++;
            $display("FAIL rst_tie: got addr=%h we=%b mask=%h want 80003000 1 3",
                     mem_addr_o, mem_we_o, mem_wmask_o);
        end
        tick();
        tick();
        checks++;
        if ({lsu_done_o, ifu_done_o} !== 2'b10) begin
            errors++;
            $display("FAIL rst_tie_done: got ld/id=%b want 10", {lsu_done_o, ifu_done_o});
        end
        lsu_req_i = 0; ifu_req_i = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_store_stall();
        test_round_robin();
        test_addr_change();
        test_stray_rvalid();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
